// File: rtl/mem_io_bridge_if.sv
// Memory request and SRAM bus bundle for mem_io_bridge.
// The bridge uses the slave modport: it is the target of the control unit's
// request and drives the SRAM strobes. The master modport is the opposite side.
interface mem_io_bridge_if;
    localparam int unsigned DW = 16;

    // Request side, between the control unit/datapath and the bridge
    logic          MEM_EN;
    logic          MEM_WE;
    logic [DW-1:0] MEM_ADDR;
    logic [DW-1:0] MEM_WDATA;
    logic [DW-1:0] MEM_RDATA;
    logic          MEM_R;

    // SRAM side
    logic [DW-1:0] SRAM_ADDR;
    logic [DW-1:0] SRAM_DOUT;
    logic [DW-1:0] SRAM_DIN;
    logic          SRAM_DQ_OE;
    logic          SRAM_CE_N;
    logic          SRAM_OE_N;
    logic          SRAM_WE_N;

    modport slave (
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, SRAM_DIN,
        output MEM_RDATA, MEM_R,
        output SRAM_ADDR, SRAM_DOUT, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N
    );

    modport master (
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, SRAM_DIN,
        input  MEM_RDATA, MEM_R,
        input  SRAM_ADDR, SRAM_DOUT, SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N
    );
endinterface

// File: rtl/mem_io_bridge.sv
// LC-3 memory bridge: one SRAM access with programmable wait states, or an
// MMIO access at IO_ADDR (read = synchronised switches, write = hex display).
// Optional feature macro: MEM_LED_PORT_EN adds a 12-bit LED register at 16'hFFFE.
module mem_io_bridge #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                  Clk,
    input  logic                  reset_n,
    mem_io_bridge_if.slave        bus,
    input  logic [15:0]           SW,
    output logic [15:0]           HEX_OUT
`ifdef MEM_LED_PORT_EN
    ,
    output logic [11:0]           LED
`endif
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
`ifdef MEM_LED_PORT_EN
    localparam int unsigned LW       = 12;
    localparam logic [DW-1:0] LED_ADDR = 16'hFFFE;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            served_q, served_d;
    logic            we_q, we_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            mem_r_q, mem_r_d;
    logic [DW-1:0]   sram_addr_q, sram_addr_d;
    logic [DW-1:0]   sram_dout_q, sram_dout_d;
    logic            dq_oe_q, dq_oe_d;
    logic            ce_n_q, ce_n_d;
    logic            oe_n_q, oe_n_d;
    logic            we_n_q, we_n_d;
    logic [DW-1:0]   hex_q, hex_d;
    logic [DW-1:0]   sw_meta_q, sw_meta_d;
    logic [DW-1:0]   sw_sync_q, sw_sync_d;
`ifdef MEM_LED_PORT_EN
    logic [LW-1:0]   led_q, led_d;
`endif

    logic accept_c;
    logic is_io_c;
    logic is_led_c;
    logic is_mmio_c;
    logic last_c;
    logic in_sram_c;

    // Request decode: accept only a fresh request while idle
    always_comb begin
        accept_c = (state_q == ST_IDLE) && bus.MEM_EN && !served_q;
        is_io_c  = (bus.MEM_ADDR == IO_ADDR);
`ifdef MEM_LED_PORT_EN
        is_led_c = (bus.MEM_ADDR == LED_ADDR);
`else
        is_led_c = 1'b0;
`endif
        is_mmio_c = is_io_c || is_led_c;
        last_c    = (cnt_q == CW'(WAIT_STATES));
    end

    // State and wait-state counter register
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; ACCESS lasts WAIT_STATES+1 cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = is_mmio_c ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = '0;
            end
            ST_ACCESS: begin
                if (last_c) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output/next-data logic; strobes are derived from the next state so they are registered
    always_comb begin
        we_d        = accept_c ? bus.MEM_WE : we_q;
        served_d    = bus.MEM_EN ? ((state_q == ST_DONE) ? 1'b1 : served_q) : 1'b0;
        rdata_d     = rdata_q;
        sram_addr_d = sram_addr_q;
        sram_dout_d = sram_dout_q;
        hex_d       = hex_q;
        sw_meta_d   = SW;
        sw_sync_d   = sw_meta_q;
`ifdef MEM_LED_PORT_EN
        led_d       = led_q;
`endif

        if (accept_c && !is_mmio_c) begin
            sram_addr_d = bus.MEM_ADDR;
            if (bus.MEM_WE) begin
                sram_dout_d = bus.MEM_WDATA;
            end
        end

        if (accept_c && is_io_c) begin
            if (bus.MEM_WE) begin
                hex_d = bus.MEM_WDATA;
            end else begin
                rdata_d = sw_sync_q;
            end
        end

`ifdef MEM_LED_PORT_EN
        if (accept_c && is_led_c) begin
            if (bus.MEM_WE) begin
                led_d = bus.MEM_WDATA[LW-1:0];
            end else begin
                rdata_d = {(DW-LW)'(0), led_q};
            end
        end
`endif

        if ((state_q == ST_ACCESS) && last_c && !we_q) begin
            rdata_d = bus.SRAM_DIN;
        end

        in_sram_c = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        ce_n_d    = !in_sram_c;
        oe_n_d    = !((state_d == ST_ACCESS) && !we_d);
        we_n_d    = !((state_d == ST_ACCESS) && we_d);
        dq_oe_d   = in_sram_c && we_d;
        mem_r_d   = (state_d == ST_DONE);
    end

    // Datapath and output registers; reset forces strobes inactive immediately
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            served_q    <= 1'b0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            mem_r_q     <= 1'b0;
            sram_addr_q <= '0;
            sram_dout_q <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            hex_q       <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
`ifdef MEM_LED_PORT_EN
            led_q       <= '0;
`endif
        end else begin
            served_q    <= served_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            mem_r_q     <= mem_r_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            hex_q       <= hex_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
`ifdef MEM_LED_PORT_EN
            led_q       <= led_d;
`endif
        end
    end

    assign bus.MEM_RDATA  = rdata_q;
    assign bus.MEM_R      = mem_r_q;
    assign bus.SRAM_ADDR  = sram_addr_q;
    assign bus.SRAM_DOUT  = sram_dout_q;
    assign bus.SRAM_DQ_OE = dq_oe_q;
    assign bus.SRAM_CE_N  = ce_n_q;
    assign bus.SRAM_OE_N  = oe_n_q;
    assign bus.SRAM_WE_N  = we_n_q;
    assign HEX_OUT        = hex_q;
`ifdef MEM_LED_PORT_EN
    assign LED            = led_q;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Bench for mem_io_bridge: directed steps plus randomized accesses, checked
// against a transaction-level memory/register model kept in the bench.
module tb_mem_io_bridge;

    localparam int WS = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = '0;
    logic [15:0] hex;
`ifdef MEM_LED_PORT_EN
    logic [11:0] led;
`endif

    int tests = 0;
    int fails = 0;

    // Reference state: what software would expect to observe
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] exp_rdata = '0;
    logic [15:0] exp_hex   = '0;
    logic [11:0] exp_led   = '0;

    // Behavioural SRAM device connected to the bus
    logic [15:0] dev_mem [logic [15:0]];

    mem_io_bridge_if bus ();

    mem_io_bridge #(
        .WAIT_STATES (WS),
        .IO_ADDR     (16'hFFFF)
    ) dut (
        .Clk     (clk),
        .reset_n (rst_n),
        .bus     (bus),
        .SW      (sw),
        .HEX_OUT (hex)
`ifdef MEM_LED_PORT_EN
        ,
        .LED     (led)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    function automatic bit is_mmio(input logic [15:0] a);
`ifdef MEM_LED_PORT_EN
        return (a == 16'hFFFF) || (a == 16'hFFFE);
`else
        return (a == 16'hFFFF);
`endif
    endfunction

    always @(posedge clk) begin
        if (!bus.SRAM_CE_N && !bus.SRAM_WE_N && bus.SRAM_DQ_OE)
            dev_mem[bus.SRAM_ADDR] = bus.SRAM_DOUT;
    end

    always @(negedge clk) begin
        if (!bus.SRAM_CE_N && !bus.SRAM_OE_N)
            bus.SRAM_DIN = dev_mem.exists(bus.SRAM_ADDR) ? dev_mem[bus.SRAM_ADDR] : dflt(bus.SRAM_ADDR);
        else
            bus.SRAM_DIN = 16'hDEAD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ce_n"},  32'(bus.SRAM_CE_N),  32'd1);
        check({tag, "_oe_n"},  32'(bus.SRAM_OE_N),  32'd1);
        check({tag, "_we_n"},  32'(bus.SRAM_WE_N),  32'd1);
        check({tag, "_dq_oe"}, 32'(bus.SRAM_DQ_OE), 32'd0);
        check({tag, "_mem_r"}, 32'(bus.MEM_R),      32'd0);
    endtask

    // One complete access; caller is just after a rising edge with MEM_EN low
    task automatic access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input bit scramble, input bit drop_en);
        int lat = -1;
        int ce = 0, oe = 0, wen = 0, dq = 0, clash = 0;
        int ce_first = 0, str_first = 0;
        logic [15:0] addr_seen = '0;
        logic [15:0] dout_seen = '0;
        bit mmio;
        mmio = is_mmio(addr);
        bus.MEM_EN = 1'b1;
        bus.MEM_WE = we;
        bus.MEM_ADDR = addr;
        bus.MEM_WDATA = wdata;
        for (int k = 1; k <= 25; k++) begin
            @(posedge clk);
            #1;
            if (k == 1 && scramble) begin
                bus.MEM_ADDR  = 16'($urandom);
                bus.MEM_WDATA = 16'($urandom);
                bus.MEM_WE    = ~we;
            end
            if (k == 1 && drop_en) bus.MEM_EN = 1'b0;
            if (!bus.SRAM_CE_N) begin
                ce++;
                addr_seen = bus.SRAM_ADDR;
                if (ce_first == 0) ce_first = k;
            end
            if (!bus.SRAM_OE_N) oe++;
            if (!bus.SRAM_WE_N) begin
                wen++;
                dout_seen = bus.SRAM_DOUT;
            end
            if ((!bus.SRAM_OE_N || !bus.SRAM_WE_N) && str_first == 0) str_first = k;
            if (bus.SRAM_DQ_OE) dq++;
            if (!bus.SRAM_OE_N && !bus.SRAM_WE_N) clash++;
            if (bus.MEM_R) begin
                lat = k;
                break;
            end
        end
        bus.MEM_EN = 1'b0;

        if (mmio) begin
            if (addr == 16'hFFFF) begin
                if (we) exp_hex = wdata; else exp_rdata = sw;
            end else begin
                if (we) exp_led = wdata[11:0]; else exp_rdata = {4'h0, exp_led};
            end
        end else begin
            if (we) ref_mem[addr] = wdata;
            else exp_rdata = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
        end

        check("latency",   32'(lat),  mmio ? 32'd1 : 32'(3 + WS));
        check("ce_cycles", 32'(ce),   mmio ? 32'd0 : 32'(2 + WS));
        check("ce_first",  32'(ce_first), mmio ? 32'd0 : 32'd1);
        check("oe_cycles", 32'(oe),   (mmio || we) ? 32'd0 : 32'(1 + WS));
        check("we_cycles", 32'(wen),  (mmio || !we) ? 32'd0 : 32'(1 + WS));
        check("dq_cycles", 32'(dq),   (mmio || !we) ? 32'd0 : 32'(2 + WS));
        check("strobe_first", 32'(str_first), mmio ? 32'd0 : 32'd2);
        check("oe_we_clash", 32'(clash), 32'd0);
        if (!mmio) check("sram_addr", 32'(addr_seen), 32'(addr));
        if (!mmio && we) check("sram_dout", 32'(dout_seen), 32'(wdata));
        check("mem_rdata", 32'(bus.MEM_RDATA), 32'(exp_rdata));
        check("hex_out",   32'(hex),           32'(exp_hex));
`ifdef MEM_LED_PORT_EN
        check("led",       32'(led),           32'(exp_led));
`endif
        @(posedge clk);
        #1;
        check("mem_r_single", 32'(bus.MEM_R), 32'd0);
        check("rdata_hold", 32'(bus.MEM_RDATA), 32'(exp_rdata));
    endtask

    initial begin
        int pulses;
        logic [15:0] a;
        bus.MEM_EN    = 1'b0;
        bus.MEM_WE    = 1'b0;
        bus.MEM_ADDR  = '0;
        bus.MEM_WDATA = '0;
        dev_mem[16'h3000] = 16'h1234;
        ref_mem[16'h3000] = 16'h1234;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        check("reset_rdata", 32'(bus.MEM_RDATA), 32'd0);
        check("reset_hex",   32'(hex),           32'd0);
        check("reset_saddr", 32'(bus.SRAM_ADDR), 32'd0);
        check("reset_sdout", 32'(bus.SRAM_DOUT), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // SRAM read, SRAM write, MMIO write/read
        access(1'b0, 16'h3000, 16'h0000, 1'b0, 1'b0);
        access(1'b1, 16'h3001, 16'hBEEF, 1'b0, 1'b0);
        access(1'b0, 16'h3001, 16'h0000, 1'b0, 1'b0);
        access(1'b1, 16'hFFFF, 16'h00A5, 1'b0, 1'b0);
        sw = 16'h0F0F;
        repeat (3) @(posedge clk);
        #1;
        access(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0);

        // Held MEM_EN yields exactly one access; a one-cycle drop rearms
        bus.MEM_EN = 1'b1; bus.MEM_WE = 1'b0; bus.MEM_ADDR = 16'h3000;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.MEM_R) pulses++;
        end
        check("held_pulses", 32'(pulses), 32'd1);
        exp_rdata = 16'h1234;
        check("held_rdata", 32'(bus.MEM_RDATA), 32'(exp_rdata));
        bus.MEM_EN = 1'b0;
        @(posedge clk); #1;
        bus.MEM_EN = 1'b1;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.MEM_R) pulses++;
        end
        check("rearm_pulses", 32'(pulses), 32'd1);
        bus.MEM_EN = 1'b0;
        @(posedge clk); #1;

        // Address/enable changes mid-access are ignored
        access(1'b1, 16'h3002, 16'hC0DE, 1'b1, 1'b0);
        access(1'b0, 16'h3002, 16'h0000, 1'b1, 1'b1);

        // Reset asserted during ACCESS of a write
        bus.MEM_EN = 1'b1; bus.MEM_WE = 1'b1; bus.MEM_ADDR = 16'h5555; bus.MEM_WDATA = 16'h1111;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_pre_we_n", 32'(bus.SRAM_WE_N), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid_rdata", 32'(bus.MEM_RDATA), 32'd0);
        check("rst_mid_hex",   32'(hex),           32'd0);
        check("rst_mid_saddr", 32'(bus.SRAM_ADDR), 32'd0);
        check("rst_mid_sdout", 32'(bus.SRAM_DOUT), 32'd0);
        bus.MEM_EN = 1'b0;
        exp_rdata = '0;
        exp_hex = '0;
        exp_led = '0;
        sw = '0;
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (bus.MEM_R) pulses++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (bus.MEM_R) pulses++;
        end
        check("rst_no_mem_r", 32'(pulses), 32'd0);
        access(1'b0, 16'h5555, 16'h0000, 1'b0, 1'b0);

        // 16'hFFFE: LED register when enabled, plain SRAM otherwise
        access(1'b1, 16'hFFFE, 16'h0ABC, 1'b0, 1'b0);
        access(1'b0, 16'hFFFE, 16'h0000, 1'b0, 1'b0);

        // Randomized mix against the reference model
        for (int i = 0; i < 40; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0) a = 16'hFFFF;
            else if (r == 1) a = 16'hFFFE;
            else a = 16'h4000 + 16'(r);
            if ($urandom_range(0, 3) == 0) begin
                sw = 16'($urandom);
                repeat (3) @(posedge clk);
                #1;
            end
            access(1'($urandom_range(0, 1)), a, 16'($urandom),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
